ofmd_wr_quant: RTL

Requantisation and write stage for the output feature map (OFMD) of the 2D-convolution datapath. It takes wide signed accumulator results from the MAC array, each paired with the write address from the OFMD write-address counter. For each result it applies a rounding right-shift, optional ReLU and signed saturation, then drives the OFMD SRAM write port. It counts the writes of one output tile and reports completion to the top-level controller.

---
 rtl/conv_pkg.sv | 28 ++
 rtl/ofmd_wr_quant_round_sat.sv | 48 ++++
 rtl/ofmd_wr_quant.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the 2D-convolution datapath: default widths,
// the write-stage FSM encoding and the signed saturation limits.
package conv_pkg;

    localparam int ACC_WIDTH_DEF  = 20;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 6;
    localparam int OFMD_SIZE_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } wrq_state_t;

    function automatic int sat_max(input int dw);
        return (1 << (dw - 1)) - 1;
    endfunction

    function automatic int sat_min(input int dw);
        return -(1 << (dw - 1));
    endfunction

    localparam int SAT_MAX = sat_max(DATA_WIDTH_DEF);
    localparam int SAT_MIN = sat_min(DATA_WIDTH_DEF);

endpackage

// File: rtl/ofmd_wr_quant_round_sat.sv
// Combinational requantiser: round-half-up arithmetic right shift,
// optional ReLU, then clamp to the signed output word range.
module round_sat
    import conv_pkg::*;
#(
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [ACC_WIDTH-1:0]  acc,
    input  logic [4:0]            shift,
    input  logic                  relu,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  sat
);

    // One extra bit so the rounding bias can never overflow the sum.
    localparam int EW = ACC_WIDTH + 1;
    localparam logic signed [EW-1:0] MAX_V = EW'(sat_max(DATA_WIDTH));
    localparam logic signed [EW-1:0] MIN_V = EW'(sat_min(DATA_WIDTH));

    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] bias;
    logic signed [EW-1:0] sum;
    logic signed [EW-1:0] shr;

    // Round, shift, then ReLU has priority over clamping (a zeroed value is not a saturation).
    always_comb begin
        ext  = $signed({acc[ACC_WIDTH-1], acc});
        bias = '0;
        if (shift != 5'd0) begin
            bias = EW'(1) << (shift - 5'd1);
        end
        sum  = ext + bias;
        shr  = sum >>> shift;
        data = shr[DATA_WIDTH-1:0];
        sat  = 1'b0;
        if (relu && shr[EW-1]) begin
            data = '0;
        end else if (shr > MAX_V) begin
            data = MAX_V[DATA_WIDTH-1:0];
            sat  = 1'b1;
        end else if (shr < MIN_V) begin
            data = MIN_V[DATA_WIDTH-1:0];
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/ofmd_wr_quant.sv
// OFMD write stage: two-stage requantise pipeline feeding the SRAM write
// port, with per-tile write and saturation counters and a completion pulse.
//
// state | meaning
// IDLE  | waiting for start; stray acc_valid dropped
// RUN   | accepting accumulator results until OFMD_SIZE taken
// DRAIN | tile fully accepted, pipeline emptying
// DONE  | one-cycle completion pulse
module ofmd_wr_quant
    import conv_pkg::*;
#(
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int OFMD_SIZE  = OFMD_SIZE_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4:0]            cfg_shift,
    input  logic                  cfg_relu,
    input  logic                  acc_valid,
    input  logic [ACC_WIDTH-1:0]  acc_data,
    input  logic [ADDR_WIDTH-1:0] wr_addr_in,
    output logic                  ofmd_we,
    output logic [ADDR_WIDTH-1:0] ofmd_addr,
    output logic [DATA_WIDTH-1:0] ofmd_wdata,
    output logic [ADDR_WIDTH:0]   wr_cnt,
    output logic [7:0]            sat_cnt,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH:0] LAST_CNT = (ADDR_WIDTH+1)'(OFMD_SIZE - 1);

    wrq_state_t state_q, state_d;

    logic                  tile_start;
    logic                  accept;
    logic [ADDR_WIDTH:0]   acc_cnt;
    logic [4:0]            shift_q;
    logic                  relu_q;

    logic                  s1_valid;
    logic [ACC_WIDTH-1:0]  s1_data;
    logic [ADDR_WIDTH-1:0] s1_addr;

    logic [DATA_WIDTH-1:0] rs_data;
    logic                  rs_sat;

    // Next-state logic; results are only taken in RUN, which ends on the last one.
    always_comb begin
        state_d    = state_q;
        tile_start = 1'b0;
        accept     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tile_start = 1'b1;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                if (acc_valid) begin
                    accept = 1'b1;
                    if (acc_cnt == LAST_CNT) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Stage 1 empty means the final write is on the port this cycle.
                if (!s1_valid) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Tile configuration and accepted-result count, captured when a tile starts.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shift_q <= '0;
            relu_q  <= 1'b0;
            acc_cnt <= '0;
        end else if (tile_start) begin
            shift_q <= cfg_shift;
            relu_q  <= cfg_relu;
            acc_cnt <= '0;
        end else if (accept) begin
            acc_cnt <= acc_cnt + 1'b1;
        end
    end

    // Stage 1: register accepted result with its address.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_addr  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_data <= acc_data;
                s1_addr <= wr_addr_in;
            end
        end
    end

    round_sat #(
        .ACC_WIDTH  (ACC_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_round_sat (
        .acc   (s1_data),
        .shift (shift_q),
        .relu  (relu_q),
        .data  (rs_data),
        .sat   (rs_sat)
    );

    // Stage 2: drive the SRAM write port; saturations are counted as they are written.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ofmd_we    <= 1'b0;
            ofmd_addr  <= '0;
            ofmd_wdata <= '0;
            sat_cnt    <= '0;
        end else begin
            ofmd_we <= s1_valid;
            if (s1_valid) begin
                ofmd_addr  <= s1_addr;
                ofmd_wdata <= rs_data;
            end
            if (tile_start) begin
                sat_cnt <= '0;
            end else if (s1_valid && rs_sat && (sat_cnt != 8'hFF)) begin
                sat_cnt <= sat_cnt + 8'd1;
            end
        end
    end

    // Write counter follows the write enable, so it lands on OFMD_SIZE with done.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_cnt <= '0;
        end else if (tile_start) begin
            wr_cnt <= '0;
        end else if (ofmd_we) begin
            wr_cnt <= wr_cnt + 1'b1;
        end
    end

    assign busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done = (state_q == ST_DONE);

endmodule
